// File: rtl/adder_arb_pkg.sv
// Shared constants and state type for the shared-adder arbiter.
package adder_arb_pkg;

  localparam int ADDER_W         = 32;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/CarrySelectAdder_32_bit.sv
// 32-bit carry-select adder built from 4-bit blocks; each upper block
// precomputes both carry-in cases and the incoming carry picks one.
module CarrySelectAdder_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar k = 0; k < 8; k++) begin : g_blk
    logic [4:0] res0;
    logic [4:0] res1;

    assign res0 = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
    assign res1 = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + 5'd1;

    assign sum[4*k +: 4] = carry[k] ? res1[3:0] : res0[3:0];
    assign carry[k+1]    = carry[k] ? res1[4]   : res0[4];
  end

  assign cout = carry[8];

endmodule

// File: rtl/adder_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above
// rr_ptr, wrapping from NUM_REQ-1 back to 0.
module adder_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_vld                                = 1'b1;
        grant_idx                                = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        grant[(int'(rr_ptr) + k) % NUM_REQ]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one carry-select adder among NUM_REQ requesters.
// Optional signed-overflow output rsp_ovf when ADDER_ARB_OVF_EN is defined.
//
// state | meaning
// EMPTY | no result held; any granted request is accepted
// FULL  | result held on rsp_*; reloaded only when rsp_ready is high
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDER_W-1:0] req_a,
  input  logic [NUM_REQ*ADDER_W-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [ADDER_W-1:0]         rsp_sum,
  output logic                       rsp_cout
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                       rsp_ovf
`endif
);

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [ID_W-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_vld;
  logic                  can_load;
  logic                  accept;
  logic [ADDER_W-1:0]    a_sel;
  logic [ADDER_W-1:0]    b_sel;
  logic [ADDER_W-1:0]    sum_c;
  logic                  cout_c;

  adder_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign rsp_valid = (state_q == FULL);
  assign can_load  = !rsp_valid || rsp_ready;
  assign req_ready = grant & {NUM_REQ{can_load}};
  assign accept    = grant_vld && can_load;

  assign a_sel = req_a[int'(grant_idx)*ADDER_W +: ADDER_W];
  assign b_sel = req_b[int'(grant_idx)*ADDER_W +: ADDER_W];

  CarrySelectAdder_32_bit u_adder (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (1'b0),
    .sum  (sum_c),
    .cout (cout_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else if (accept) begin
      rr_ptr   <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      rsp_id   <= grant_idx;
      rsp_sum  <= sum_c;
      rsp_cout <= cout_c;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  // Operands agree in sign but the result does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (accept) begin
      rsp_ovf <= (a_sel[ADDER_W-1] == b_sel[ADDER_W-1]) &&
                 (sum_c[ADDER_W-1] != a_sel[ADDER_W-1]);
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (NUM_REQ=4).
module tb_adder_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;
`ifdef ADDER_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  adder_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  logic [31:0] fair_sum [4];
  logic [31:0] held_sum;

  initial begin
    fair_sum[0] = 32'h1000_0100;
    fair_sum[1] = 32'h2000_0201;
    fair_sum[2] = 32'h3000_0302;
    fair_sum[3] = 32'h4000_0403;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    #12;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_sum",   64'(rsp_sum),   64'd0);
    chk("rst_cout",  64'(rsp_cout),  64'd0);
    chk("rst_id",    64'(rsp_id),    64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
`ifdef ADDER_ARB_OVF_EN
    chk("rst_ovf",   64'(rsp_ovf),   64'd0);
`endif
    rst_n = 1'b1;
    step();

    // Fairness: everyone valid, consumer always ready.
    set_op(0, 32'h1000_0000, 32'h0000_0100);
    set_op(1, 32'h2000_0001, 32'h0000_0200);
    set_op(2, 32'h3000_0002, 32'h0000_0300);
    set_op(3, 32'h4000_0003, 32'h0000_0400);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      step();
      chk("fair_valid", 64'(rsp_valid), 64'd1);
      chk("fair_id",    64'(rsp_id),    64'(k % 4));
      chk("fair_sum",   64'(rsp_sum),   64'(fair_sum[k % 4]));
    end
    req_valid = '0;

    // Single request from requester 2 (pointer now at 2).
    set_op(2, 32'h0000_0005, 32'h0000_0007);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_sum",   64'(rsp_sum),   64'h0000_000C);
    chk("single_cout",  64'(rsp_cout),  64'd0);
    chk("single_id",    64'(rsp_id),    64'd2);

    // Carry out via requester 0 (pointer at 3 wraps to 0).
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 4'b0001;
    #1;
    chk("carry_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    chk("carry_sum",  64'(rsp_sum),  64'd0);
    chk("carry_cout", 64'(rsp_cout), 64'd1);
    chk("carry_id",   64'(rsp_id),   64'd0);
`ifdef ADDER_ARB_OVF_EN
    chk("carry_ovf",  64'(rsp_ovf),  64'd0);
`endif

    // Signed overflow case via requester 1.
    set_op(1, 32'h7FFF_FFFF, 32'h0000_0001);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    chk("ovf_sum",  64'(rsp_sum),  64'h8000_0000);
    chk("ovf_cout", 64'(rsp_cout), 64'd0);
    chk("ovf_id",   64'(rsp_id),   64'd1);
`ifdef ADDER_ARB_OVF_EN
    chk("ovf_flag", 64'(rsp_ovf),  64'd1);
`endif

    // Backpressure: hold the result for 5 cycles with everyone requesting.
    set_op(2, 32'h8000_0000, 32'h8000_0001);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    held_sum  = 32'h8000_0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      step();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_sum",   64'(rsp_sum),   64'(held_sum));
      chk("bp_id",    64'(rsp_id),    64'd1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    chk("bp_new_id",   64'(rsp_id),   64'd2);
    chk("bp_new_sum",  64'(rsp_sum),  64'h0000_0001);
    chk("bp_new_cout", 64'(rsp_cout), 64'd1);
    step();
    chk("drain_valid", 64'(rsp_valid), 64'd0);

    // Requester 0 accepted (pointer 3 -> 0, then moves to 1), result held.
    set_op(0, 32'h1234_5678, 32'h1111_1111);
    set_op(3, 32'h0000_0009, 32'h0000_0001);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("pre_rst_sum", 64'(rsp_sum), 64'h2345_6789);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_sum",   64'(rsp_sum),   64'd0);
    chk("mid_rst_id",    64'(rsp_id),    64'd0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    chk("post_rst_id",  64'(rsp_id),  64'd0);
    chk("post_rst_sum", 64'(rsp_sum), 64'h2345_6789);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
